serpent_key_schedule_stream: RTL and testbench
==============================================

Name: serpent_key_schedule_stream

Overview:
Parametrised Serpent key-schedule engine. It pads a 128/192/256-bit user key, which is selected at run time, and expands it through the phi/rotate prekey recurrence. It applies the bitsliced S-box to produce NUM_SUBKEYS 128-bit round subkeys, with no IP permutation. Subkeys stream out over a valid/ready handshake to the round-key RAM writer in front of the bitslice cipher core. This successor adds key-length select, configurable generation throughput, backpressure and completion/error flags.

Parameters:
WPC, 1, prekey words generated per cycle; legal values are 1, 2 and 4; cycles per subkey = 4/WPC.
NUM_SUBKEYS, 33, subkeys produced per run (ROUNDS+1); range 1..33.
AW, 6, o_address width; must satisfy 2**AW >= NUM_SUBKEYS.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_begin  in  1  start request; sampled only in IDLE.
i_key_len  in  2  0=128, 1=192, 2=256, 3=reserved; sampled with i_begin.
i_key  in  256  user key; i_key[31:0]=w[-8] ... i_key[255:224]=w[-1]; sampled with i_begin.
i_subkey_ready  in  1  consumer accepts the presented subkey.
o_subkey  out  128  {K[3],K[2],K[1],K[0]}, K[0] in bits [31:0].
o_address  out  AW  subkey index j.
o_subkey_valid  out  1  o_subkey/o_address valid.
o_busy  out  1  high from the i_begin edge until o_done.
o_done  out  1  one-cycle pulse after the last subkey is accepted.
o_err  out  1  one-cycle pulse when i_begin is accepted with i_key_len=3.

Behaviour:
- Reset, when i_rst=1 at an edge: FSM goes to IDLE. o_subkey=0, o_address=0, o_subkey_valid=0, o_busy=0, o_done=0, o_err=0. Window, word counter and subkey counter clear. Reset has priority over everything and aborts any run mid-operation.
- Padding, L=128/192/256: bits [L-1:0] come from i_key, bit L=1 when L<256, and all bits above L are 0. For i_key_len=3, o_err pulses on the next edge and the key is treated as 256-bit.
- States: IDLE -> GEN on i_begin. GEN -> OUT after 4/WPC word cycles. OUT -> GEN when accepted and j<NUM_SUBKEYS-1. OUT -> DONE when accepted and j=NUM_SUBKEYS-1. DONE -> IDLE unconditionally after 1 cycle, with o_done=1 during DONE.
- IDLE with i_begin=1: the padded key loads into the 8-word sliding window. Word index i=0, j=0, o_busy=1.
- GEN: each cycle produces WPC words. For each word: w[i]=ROL32(w[i-8]^w[i-5]^w[i-3]^w[i-1]^32'h9E3779B9^i, 11). Words produced in the same cycle chain combinationally. The window shifts by WPC. i is 8 bits wide; the final i is 4*NUM_SUBKEYS-1 and i never wraps.
- Subkey j uses S-box index (3-j) mod 8, applied bitsliced over words w[4j..4j+3]: bit b of K[0..3] = S(bit b of w[4j], w[4j+1], w[4j+2], w[4j+3]), with the input LSB from w[4j]. The result is registered into o_subkey and o_subkey_valid rises.
- Latency: the first o_subkey_valid rises 4/WPC + 1 edges after the i_begin-sampling edge. With WPC=4 and the output register empty or being accepted, generation overlaps the handshake. Sustained throughput is then 1 subkey per cycle with ready held high, or 1 subkey per 4/WPC cycles in general.
- Handshake: a transfer occurs on an edge where o_subkey_valid and i_subkey_ready are both 1. While valid=1 and ready=0, o_subkey and o_address hold stable, and generation stalls once the next word set is complete. o_subkey_valid never drops without a transfer, except on reset.
- i_begin while o_busy=1 is ignored, with no restart. i_key and i_key_len are don't-care outside IDLE.
- o_address equals j for every presented subkey. Addresses run 0..NUM_SUBKEYS-1 strictly in order.

Decomposition:
- Shared package serpent_pkg: PHI constant 32'h9E3779B9, SBOX[0:7] 4-bit tables, KEY_LEN_128/192/256 encodings, and the ROL11 function.
- One sub-module, serpent_sbox_slice: takes a 3-bit S-box index and four 32-bit words and returns four 32-bit words, purely combinational. It is shared with the cipher core.

Test Plan:
- All-zero key, len=2, WPC=4, ready held high: exactly 33 valid beats on consecutive cycles with addresses 0..32. The first valid comes 2 edges after i_begin. o_done pulses on the edge after beat 32. Internal w[0] = 32'hBBCDCCF1. All subkeys match the C reference model.
- Padding equivalence: a 128-bit key K with len=0, and i_key={127'b0,1'b1,K} with len=2, produce 33 identical subkeys. The same check applies to a 192-bit key with bit 192 set.
- Backpressure with WPC=1: ready is deasserted for 5 cycles at j=7, then toggled randomly. o_subkey and o_address hold stable while stalled. No beat is lost or duplicated. The total is 33 beats.
- len=3 with a random key: o_err pulses once, and the subkeys equal those of the same key with len=2.
- Reset mid-run: i_rst=1 at j=12. On the next edge valid, busy and done are all 0. A new i_begin restarts from address 0 with correct subkeys.
- i_begin re-asserted at j=5 during a run: it is ignored. The run completes 33 beats for the original key.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared definitions for the Serpent key schedule and the bitslice cipher core.
// Contents: golden-ratio constant, the eight 4-bit S-box tables, key-length encodings,
// the FSM state type of the key-schedule engine, and the rotate/padding helpers.
// No ports (package).
package serpent_pkg;

    localparam logic [31:0] PHI = 32'h9E3779B9;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    // S-box n is packed with entry x in bits [4x+3:4x].
    localparam logic [63:0] SBOX [8] = '{
        64'hC90724DEB56A1F83,
        64'h43D68EB1A50972CF,
        64'h25B04E1DFAC39768,
        64'hE57A421D369C8BF0,
        64'hD7E9A4526B0C38F1,
        64'h176D8E30C9A4B25F,
        64'h0A3DF19EB6485C27,
        64'h6539AC47B28E0FD1
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ks_state_e;

    function automatic logic [31:0] rol11(input logic [31:0] x);
        return {x[20:0], x[31:21]};
    endfunction

    // Short keys get a single 1 bit directly above the key, zeros beyond it.
    // The reserved encoding is handled as a full 256-bit key.
    function automatic logic [255:0] pad_key(input logic [255:0] key, input logic [1:0] len);
        logic [255:0] p;
        case (len)
            KEY_LEN_128:  p = {127'd0, 1'b1, key[127:0]};
            KEY_LEN_192:  p = {63'd0, 1'b1, key[191:0]};
            KEY_LEN_256:  p = key;
            KEY_LEN_RSVD: p = key;
            default:      p = key;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/serpent_sbox_slice.sv
// Bitsliced Serpent S-box: applies S-box sel_i to each of the 32 bit positions of
// four words. Bit b of x0_i is the input LSB, bit b of x3_i the MSB; output bit k
// of the S-box lands in bit b of y<k>_o. Purely combinational.
//   sel_i        S-box index 0..7
//   x0_i..x3_i   input words
//   y0_o..y3_o   output words
module serpent_sbox_slice
    import serpent_pkg::*;
(
    input  logic [2:0]  sel_i,
    input  logic [31:0] x0_i,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    input  logic [31:0] x3_i,
    output logic [31:0] y0_o,
    output logic [31:0] y1_o,
    output logic [31:0] y2_o,
    output logic [31:0] y3_o
);

    logic [63:0] table_w;

    assign table_w = SBOX[sel_i];

    always_comb begin
        logic [3:0] in_nib;
        logic [3:0] out_nib;
        y0_o = '0;
        y1_o = '0;
        y2_o = '0;
        y3_o = '0;
        for (int b = 0; b < 32; b++) begin
            in_nib  = {x3_i[b], x2_i[b], x1_i[b], x0_i[b]};
            out_nib = table_w[{in_nib, 2'b00} +: 4];
            y0_o[b] = out_nib[0];
            y1_o[b] = out_nib[1];
            y2_o[b] = out_nib[2];
            y3_o[b] = out_nib[3];
        end
    end

endmodule

// File: rtl/serpent_key_schedule_stream.sv
// Serpent key-schedule engine. Pads a 128/192/256-bit user key, runs the prekey
// recurrence WPC words per cycle through an 8-word sliding window, and streams
// NUM_SUBKEYS bitsliced subkeys over a valid/ready handshake.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_begin             start request (IDLE only), i_key_len / i_key sampled with it
//   i_subkey_ready      consumer accepts the presented subkey
//   o_subkey            {K3,K2,K1,K0}; o_address = subkey index; o_subkey_valid
//   o_busy              run in progress; o_done one-cycle completion pulse
//   o_err               one-cycle pulse when a run starts with the reserved key length
module serpent_key_schedule_stream
    import serpent_pkg::*;
#(
    parameter int unsigned WPC         = 1,
    parameter int unsigned NUM_SUBKEYS = 33,
    parameter int unsigned AW          = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_begin,
    input  logic [1:0]    i_key_len,
    input  logic [255:0]  i_key,
    input  logic          i_subkey_ready,
    output logic [127:0]  o_subkey,
    output logic [AW-1:0] o_address,
    output logic          o_subkey_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned CPS = 4 / WPC;
    localparam int unsigned CW  = $clog2(NUM_SUBKEYS + 1);

    localparam logic [1:0]    GEN_LAST  = 2'(CPS - 1);
    localparam logic [CW-1:0] NUM_SETS  = CW'(NUM_SUBKEYS);
    localparam logic [CW-1:0] LAST_SET  = CW'(NUM_SUBKEYS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SUBKEYS - 1);

    ks_state_e       state_q, state_d;
    logic [31:0]     win_q [8];
    logic [31:0]     win_d [8];
    logic [7:0]      idx_q, idx_d;
    logic [1:0]      gcnt_q, gcnt_d;
    // Window slots 4..7 hold a finished word set not yet moved to the output register.
    logic            full_q, full_d;
    // Number of subkeys moved into the output register so far (= index of the set in flight).
    logic [CW-1:0]   nsets_q, nsets_d;
    logic [127:0]    sk_q, sk_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            vld_q, vld_d;
    logic            err_q, err_d;

    logic [31:0]     ext [8 + WPC];
    logic [255:0]    padded;
    logic [2:0]      sbox_sel;
    logic [31:0]     k0, k1, k2, k3;
    logic            accept, load, gen_en;

    assign padded   = pad_key(i_key, i_key_len);
    assign sbox_sel = 3'd3 - 3'(nsets_q);

    // Words produced in one cycle chain: later ones see the earlier ones of the same cycle.
    always_comb begin
        for (int m = 0; m < 8; m++) begin
            ext[m] = win_q[m];
        end
        for (int k = 0; k < WPC; k++) begin
            ext[8 + k] = rol11(ext[k] ^ ext[k + 3] ^ ext[k + 5] ^ ext[k + 7] ^ PHI
                               ^ {24'd0, idx_q + 8'(k)});
        end
    end

    serpent_sbox_slice u_sbox (
        .sel_i (sbox_sel),
        .x0_i  (win_q[4]),
        .x1_i  (win_q[5]),
        .x2_i  (win_q[6]),
        .x3_i  (win_q[7]),
        .y0_o  (k0),
        .y1_o  (k1),
        .y2_o  (k2),
        .y3_o  (k3)
    );

    assign accept = vld_q & i_subkey_ready;
    assign load   = (state_q == StRun) && full_q && (!vld_q || i_subkey_ready);
    // A held set only frees the window when it moves out; then the next set may start.
    assign gen_en = (state_q == StRun) &&
                    (full_q ? (load && (nsets_q != LAST_SET)) : (nsets_q < NUM_SETS));

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        full_d  = full_q;
        nsets_d = nsets_q;
        sk_d    = sk_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_begin) begin
                    for (int m = 0; m < 8; m++) begin
                        win_d[m] = padded[32*m +: 32];
                    end
                    idx_d   = '0;
                    gcnt_d  = '0;
                    full_d  = 1'b0;
                    nsets_d = '0;
                    err_d   = (i_key_len == KEY_LEN_RSVD);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (gen_en) begin
                    for (int m = 0; m < 8; m++) begin
                        win_d[m] = ext[m + WPC];
                    end
                    idx_d  = idx_q + 8'(WPC);
                    gcnt_d = (gcnt_q == GEN_LAST) ? 2'd0 : gcnt_q + 2'd1;
                end
                if (gen_en && (gcnt_q == GEN_LAST)) begin
                    full_d = 1'b1;
                end else if (load) begin
                    full_d = 1'b0;
                end
                if (load) begin
                    sk_d    = {k3, k2, k1, k0};
                    addr_d  = AW'(nsets_q);
                    nsets_d = nsets_q + 1'b1;
                    vld_d   = 1'b1;
                end else if (accept) begin
                    vld_d = 1'b0;
                end
                if (accept && (addr_q == LAST_ADDR)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            for (int m = 0; m < 8; m++) begin
                win_q[m] <= '0;
            end
            idx_q   <= '0;
            gcnt_q  <= '0;
            full_q  <= 1'b0;
            nsets_q <= '0;
            sk_q    <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            full_q  <= full_d;
            nsets_q <= nsets_d;
            sk_q    <= sk_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign o_subkey       = sk_q;
    assign o_address      = addr_q;
    assign o_subkey_valid = vld_q;
    assign o_busy         = (state_q == StRun);
    assign o_done         = (state_q == StDone);
    assign o_err          = err_q;

endmodule

// File: tb/tb_serpent_key_schedule_stream.sv
// Bench for serpent_key_schedule_stream: one WPC=4 and one WPC=1 instance run the same
// keys side by side; a behavioural key-schedule model supplies every expected subkey.
module tb_serpent_key_schedule_stream;

    localparam int NUM = 33;

    localparam int SB [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    logic         clk = 1'b0;
    logic         rst, beg;
    logic [1:0]   klen;
    logic [255:0] key;
    logic         rdy [2];
    logic [127:0] sk [2];
    logic [5:0]   ad [2];
    logic         vl [2], bz [2], dn [2], er [2];

    always #5 clk = ~clk;

    serpent_key_schedule_stream #(.WPC(4), .NUM_SUBKEYS(NUM), .AW(6)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_begin(beg), .i_key_len(klen), .i_key(key),
        .i_subkey_ready(rdy[0]), .o_subkey(sk[0]), .o_address(ad[0]),
        .o_subkey_valid(vl[0]), .o_busy(bz[0]), .o_done(dn[0]), .o_err(er[0])
    );

    serpent_key_schedule_stream #(.WPC(1), .NUM_SUBKEYS(NUM), .AW(6)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_begin(beg), .i_key_len(klen), .i_key(key),
        .i_subkey_ready(rdy[1]), .o_subkey(sk[1]), .o_address(ad[1]),
        .o_subkey_valid(vl[1]), .o_busy(bz[1]), .o_done(dn[1]), .o_err(er[1])
    );

    int total = 0, bad = 0;
    int cyc = 0, start_cyc = 0;
    bit chk_idle = 1'b0;
    logic [127:0] exp_sk [NUM];
    logic [127:0] save_sk [NUM];
    logic [31:0]  mw0;
    logic [255:0] mpad;

    int exp_idx [2], beats [2], done_cnt [2], err_cnt [2];
    int first_cyc [2], last_cyc [2], stall_left [2], pol [2];
    bit seen [2], prev_last [2], prev_stall [2], active [2], stall_started [2];

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] sbox_m(input int s, input logic [31:0] x0,
                                           input logic [31:0] x1, input logic [31:0] x2,
                                           input logic [31:0] x3);
        logic [31:0] k [4];
        int v, o;
        for (int bt = 0; bt < 32; bt++) begin
            v = int'(x0[bt]) + 2 * int'(x1[bt]) + 4 * int'(x2[bt]) + 8 * int'(x3[bt]);
            o = SB[s][v];
            for (int q = 0; q < 4; q++) k[q][bt] = o[q];
        end
        return {k[3], k[2], k[1], k[0]};
    endfunction

    // Straight-line key schedule: pad, expand all 4*NUM prekey words, then S-box them.
    task automatic model(input logic [255:0] kin, input int len);
        logic [255:0] p;
        logic [31:0]  w [8 + 4*NUM];
        logic [31:0]  t;
        p = kin;
        if (len == 0) p = {128'd0, kin[127:0]} | (256'd1 << 128);
        else if (len == 1) p = {64'd0, kin[191:0]} | (256'd1 << 192);
        mpad = p;
        for (int m = 0; m < 8; m++) w[m] = p[32*m +: 32];
        for (int i = 0; i < 4*NUM; i++) begin
            t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9E3779B9 ^ 32'(i);
            w[i+8] = {t[20:0], t[31:21]};
        end
        mw0 = w[8];
        for (int j = 0; j < NUM; j++)
            exp_sk[j] = sbox_m(((3 - j) % 8 + 8) % 8, w[4*j+8], w[4*j+9], w[4*j+10], w[4*j+11]);
    endtask

    task automatic monitor();
        int w;
        if (chk_idle) begin
            for (int u = 0; u < 2; u++) begin
                chk(!vl[u] && !bz[u] && !dn[u] && !er[u], "idle_flags",
                    {vl[u], bz[u], dn[u], er[u]}, 0);
                chk(sk[u] == 128'd0, "idle_subkey", sk[u], 0);
                chk(ad[u] == 6'd0, "idle_address", ad[u], 0);
            end
            chk_idle = 1'b0;
        end
        for (int u = 0; u < 2; u++) begin
            w = (u == 0) ? 4 : 1;
            if (rst) begin
                exp_idx[u] = 0; beats[u] = 0; seen[u] = 0; prev_stall[u] = 0;
                prev_last[u] = 0; active[u] = 0; stall_left[u] = 0; stall_started[u] = 0;
                rdy[u] = 1'b0;
            end else begin
                // Ready for the coming edge is chosen first; the transfer test uses it.
                if (pol[u] == 0) rdy[u] = 1'b1;
                else if (pol[u] == 1) rdy[u] = 1'($urandom_range(0, 1));
                else begin
                    if (vl[u] && exp_idx[u] == 7 && !stall_started[u]) begin
                        stall_started[u] = 1; stall_left[u] = 5;
                    end
                    if (stall_left[u] > 0) begin
                        rdy[u] = 1'b0; stall_left[u]--;
                    end else if (stall_started[u]) rdy[u] = 1'($urandom_range(0, 1));
                    else rdy[u] = 1'b1;
                end
                if (er[u]) err_cnt[u]++;
                if (dn[u]) begin
                    chk(prev_last[u], "done_after_last", {127'd0, dn[u]}, {127'd0, prev_last[u]});
                    done_cnt[u]++;
                    active[u] = 0;
                end
                prev_last[u] = 0;
                if (active[u] && cyc >= start_cyc && !dn[u])
                    chk(bz[u], "busy_in_run", bz[u], 1);
                if (vl[u]) begin
                    chk(exp_idx[u] < NUM, "extra_beat", ad[u], NUM);
                    if (exp_idx[u] < NUM) begin
                        if (!seen[u] && active[u]) begin
                            seen[u] = 1; first_cyc[u] = cyc;
                            chk(cyc - start_cyc == 4/w + 1, "first_latency",
                                128'(cyc - start_cyc), 128'(4/w + 1));
                        end
                        chk(ad[u] == 6'(exp_idx[u]), "address", ad[u], exp_idx[u]);
                        chk(sk[u] == exp_sk[exp_idx[u]], "subkey", sk[u], exp_sk[exp_idx[u]]);
                        if (rdy[u]) begin
                            last_cyc[u] = cyc;
                            prev_last[u] = (exp_idx[u] == NUM - 1);
                            exp_idx[u]++; beats[u]++; prev_stall[u] = 0;
                        end else prev_stall[u] = 1;
                    end
                end else begin
                    chk(!prev_stall[u], "valid_dropped", 0, 1);
                    prev_stall[u] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic start_run(input logic [255:0] kin, input logic [1:0] len);
        model(kin, (len == 2'd3) ? 2 : int'(len));
        for (int u = 0; u < 2; u++) begin
            exp_idx[u] = 0; beats[u] = 0; done_cnt[u] = 0; err_cnt[u] = 0;
            seen[u] = 0; prev_last[u] = 0; prev_stall[u] = 0; active[u] = 1;
            stall_left[u] = 0; stall_started[u] = 0;
        end
        key = kin; klen = len; beg = 1'b1;
        start_cyc = cyc + 1;
        tick();
        beg = 1'b0;
    endtask

    task automatic wait_done(input int exp_err);
        int n = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < 3000) begin
            tick(); n++;
        end
        chk(n < 3000, "run_timeout", n, 3000);
        tick();
        for (int u = 0; u < 2; u++) begin
            chk(beats[u] == NUM, "beat_count", beats[u], NUM);
            chk(done_cnt[u] == 1, "done_count", done_cnt[u], 1);
            chk(err_cnt[u] == exp_err, "err_count", err_cnt[u], exp_err);
        end
    endtask

    task automatic wait_idx(input int u, input int target);
        int n = 0;
        while (exp_idx[u] < target && n < 2000) begin
            tick(); n++;
        end
        chk(n < 2000, "index_timeout", exp_idx[u], target);
    endtask

    function automatic logic [255:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Shorter key's padding must equal an explicit 256-bit key carrying the pad bit.
    task automatic pad_equiv(input logic [255:0] k, input int len);
        logic [255:0] k2;
        bit same;
        k2 = (len == 0) ? ({128'd0, k[127:0]} | (256'd1 << 128))
                        : ({64'd0, k[191:0]} | (256'd1 << 192));
        model(k2, 2);
        save_sk = exp_sk;
        model(k, len);
        same = 1;
        for (int j = 0; j < NUM; j++) if (exp_sk[j] != save_sk[j]) same = 0;
        chk(same, "model_pad_equiv", exp_sk[0], save_sk[0]);
        pol = '{1, 1};
        start_run(k, 2'(len));
        wait_done(0);
        pol = '{0, 1};
        start_run(k2, 2'd2);
        wait_done(0);
    endtask

    initial begin
        logic [255:0] k;
        rst = 1'b1; beg = 1'b0; klen = 2'd0; key = '0;
        pol = '{0, 0};
        for (int u = 0; u < 2; u++) begin
            rdy[u] = 1'b0; active[u] = 0; exp_idx[u] = 0; done_cnt[u] = 0; err_cnt[u] = 0;
            beats[u] = 0; seen[u] = 0; prev_last[u] = 0; prev_stall[u] = 0;
            stall_left[u] = 0; stall_started[u] = 0; first_cyc[u] = 0; last_cyc[u] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk_idle = 1'b1;
        tick();

        // Hand-computed anchors for the model.
        chk(sbox_m(0, 32'd0, 32'd0, 32'd0, 32'd0) == {64'd0, {64{1'b1}}}, "model_sbox0",
            sbox_m(0, 32'd0, 32'd0, 32'd0, 32'd0), {64'd0, {64{1'b1}}});
        chk(sbox_m(3, '1, '1, '1, '1) == {{96{1'b1}}, 32'd0}, "model_sbox3",
            sbox_m(3, '1, '1, '1, '1), {{96{1'b1}}, 32'd0});
        model(256'd0, 0);
        chk(mpad == (256'd1 << 128), "model_pad128", mpad[191:64], 128'd1 << 64);

        // All-zero 256-bit key, ready held high: back-to-back beats on the WPC=4 unit.
        pol = '{0, 0};
        start_run(256'd0, 2'd2);
        chk(mw0 == 32'hBBCDCCF1, "model_w0", mw0, 32'hBBCDCCF1);
        wait_done(0);
        chk(last_cyc[0] - first_cyc[0] == NUM - 1, "wpc4_back_to_back",
            last_cyc[0] - first_cyc[0], NUM - 1);
        chk(last_cyc[1] - first_cyc[1] == 4 * (NUM - 1), "wpc1_spacing",
            last_cyc[1] - first_cyc[1], 4 * (NUM - 1));

        pad_equiv(rkey(), 0);
        pad_equiv(rkey(), 1);

        // Backpressure: 5-cycle stall at j=7, then random ready.
        pol = '{2, 2};
        start_run(rkey(), 2'd2);
        wait_done(0);

        // Reserved length behaves as 256-bit and flags an error once.
        pol = '{1, 0};
        start_run(rkey(), 2'd3);
        wait_done(1);

        // Reset in the middle of a run, then a clean restart.
        pol = '{0, 0};
        start_run(rkey(), 2'd1);
        wait_idx(1, 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle = 1'b1;
        start_run(rkey(), 2'd0);
        wait_done(0);

        // A second begin during a run is ignored.
        pol = '{0, 1};
        start_run(rkey(), 2'd2);
        wait_idx(0, 5);
        k = rkey();
        key = k; klen = 2'd0; beg = 1'b1;
        tick();
        beg = 1'b0;
        wait_done(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
